// File: rtl/read_address_traversal_if.sv
// read_address_traversal_if
//   Bundles the signals of the read-side ring-buffer address generator.
//   Parameter ADDR_WIDTH: address bits per SRAM chip.
//   Signals:
//     W_NEXT         writer NEXT strobe (asynchronous to the clock)
//     R_NEXT         read request, sampled by the generator while idle
//     R_ADDRESS_OUT  current read address within the selected chip
//     R_CHIP_SELECT  current read chip (0/1)
//     R_ENABLE       SRAM read enable
//     R_DATA_VALID   one-cycle pulse when SRAM read data is valid
//     R_BUSY         a read sequence is in progress
//     EMPTY / FULL   occupancy is zero / equal to the buffer depth
//     OVERRUN        sticky flag: a write arrived while the buffer was full
//     OCCUPANCY      words written but not yet read
//   Modports: slave = the generator, master = the environment driving it.
interface read_address_traversal_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  W_NEXT;
  logic                  R_NEXT;
  logic [ADDR_WIDTH-1:0] R_ADDRESS_OUT;
  logic                  R_CHIP_SELECT;
  logic                  R_ENABLE;
  logic                  R_DATA_VALID;
  logic                  R_BUSY;
  logic                  EMPTY;
  logic                  FULL;
  logic                  OVERRUN;
  logic [ADDR_WIDTH+1:0] OCCUPANCY;

  modport slave (
    input  W_NEXT, R_NEXT,
    output R_ADDRESS_OUT, R_CHIP_SELECT, R_ENABLE, R_DATA_VALID,
           R_BUSY, EMPTY, FULL, OVERRUN, OCCUPANCY
  );

  modport master (
    output W_NEXT, R_NEXT,
    input  R_ADDRESS_OUT, R_CHIP_SELECT, R_ENABLE, R_DATA_VALID,
           R_BUSY, EMPTY, FULL, OVERRUN, OCCUPANCY
  );
endinterface

// File: rtl/read_address_traversal.sv
// read_address_traversal
//   Read-side address generator for a two-chip SRAM ring buffer. The read
//   pointer {chip, address} walks the same order as the writer: the address
//   counts up and the chip select toggles when the address wraps. Writer NEXT
//   strobes are synchronised and counted to track occupancy; a small FSM runs
//   one SRAM read (SETUP, WAIT, SAMPLE, ADVANCE) per accepted request.
//   Ports:
//     CLK    system clock, all logic on the rising edge
//     RESET  synchronous active-high reset
//     bus    read_address_traversal_if.slave (see the interface for signals)
//   Parameters:
//     ADDR_WIDTH   address bits per chip; depth = 2^(ADDR_WIDTH+1) words
//     WAIT_CYCLES  cycles spent in WAIT for SRAM access time (0 allowed)
module read_address_traversal #(
  parameter int ADDR_WIDTH  = 18,
  parameter int WAIT_CYCLES = 2
) (
  input logic                      CLK,
  input logic                      RESET,
  read_address_traversal_if.slave  bus
);

  localparam int OW = ADDR_WIDTH + 2;
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [OW-1:0] DEPTH = {2'b10, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WAIT    = 3'd2,
    S_SAMPLE  = 3'd3,
    S_ADVANCE = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]    w_sync_reg;
  logic          w_prev_reg;
  logic          write_evt;
  logic          read_evt;
  logic [PW-1:0] ptr_reg;
  logic [OW-1:0] occ_reg, occ_next;
  logic          overrun_reg, overrun_next;
  logic          empty;
  logic          full;
  logic          r_enable;
  logic          r_data_valid;
  logic          r_busy;

  // Two-flop synchroniser followed by a rising-edge detector on the
  // synchronised strobe; one write_evt per writer word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      w_sync_reg <= 2'b00;
      w_prev_reg <= 1'b0;
    end else begin
      w_sync_reg <= {w_sync_reg[0], bus.W_NEXT};
      w_prev_reg <= w_sync_reg[1];
    end
  end

  assign write_evt = w_sync_reg[1] & ~w_prev_reg;

  assign empty = (occ_reg == '0);
  assign full  = (occ_reg == DEPTH);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        // Requests while empty are dropped, not remembered.
        if (bus.R_NEXT && !empty) begin
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        wait_cnt_next = CW'(WAIT_CYCLES);
        state_next    = (WAIT_CYCLES == 0) ? S_SAMPLE : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_next = wait_cnt_reg - CW'(1);
        // <= keeps the FSM from sticking if the counter were ever 0 here.
        if (wait_cnt_reg <= CW'(1)) begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE:  state_next = S_ADVANCE;
      S_ADVANCE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    r_enable     = 1'b0;
    r_data_valid = 1'b0;
    r_busy       = (state_reg != S_IDLE);
    read_evt     = 1'b0;
    case (state_reg)
      S_SETUP:   r_enable = 1'b1;
      S_WAIT:    r_enable = 1'b1;
      S_SAMPLE: begin
        r_enable     = 1'b1;
        r_data_valid = 1'b1;
      end
      S_ADVANCE: read_evt = 1'b1;
      default: ;
    endcase
  end

  // The pointer is one counter {chip, address}: the carry out of the address
  // field is exactly the chip toggle at wrap, and the whole counter wraps
  // from chip 1 all-ones back to chip 0 address 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_reg <= '0;
    end else if (read_evt) begin
      ptr_reg <= ptr_reg + PW'(1);
    end
  end

  // Occupancy: simultaneous write and read cancel, so no overrun is flagged
  // even when full. A lone write while full is dropped and flagged.
  always_comb begin
    occ_next     = occ_reg;
    overrun_next = overrun_reg;
    if (write_evt && !read_evt) begin
      if (full) begin
        overrun_next = 1'b1;
      end else begin
        occ_next = occ_reg + OW'(1);
      end
    end else if (read_evt && !write_evt) begin
      if (!empty) begin
        occ_next = occ_reg - OW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      occ_reg     <= occ_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.R_ADDRESS_OUT = ptr_reg[ADDR_WIDTH-1:0];
  assign bus.R_CHIP_SELECT = ptr_reg[ADDR_WIDTH];
  assign bus.R_ENABLE      = r_enable;
  assign bus.R_DATA_VALID  = r_data_valid;
  assign bus.R_BUSY        = r_busy;
  assign bus.EMPTY         = empty;
  assign bus.FULL          = full;
  assign bus.OVERRUN       = overrun_reg;
  assign bus.OCCUPANCY     = occ_reg;

endmodule

// File: tb/tb_read_address_traversal.sv
// tb_read_address_traversal
//   Bench for read_address_traversal with a reduced address width so that
//   wrap, full and overrun are reachable quickly. A timeline model tracks
//   occupancy, pointer and the read window of each accepted request; the
//   compare process checks every output on every cycle. Directed sections
//   add literal expectations for reset, latency, wrap, full and overrun.
module tb_read_address_traversal;
  localparam int AW    = 4;
  localparam int WC    = 2;
  localparam int DEPTH = 1 << (AW + 1);
  localparam int HALF  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  read_address_traversal_if #(.ADDR_WIDTH(AW)) bus();

  read_address_traversal #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int cyc = 0;
  int m_occ = 0;
  int m_ptr = 0;
  int m_ovr = 0;
  int rd_start = -1;
  int wr_due[$];

  // Logs of DUT reads (actual values) for directed checks
  logic [AW:0] rd_log[$];
  int          lat_log[$];
  int          last_idle = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model, advanced on each rising edge.
  initial begin
    bit we, re;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_occ = 0; m_ptr = 0; m_ovr = 0; rd_start = -1;
        wr_due.delete();
      end else begin
        we = 0; re = 0;
        while (wr_due.size() > 0 && wr_due[0] <= cyc) begin
          if (wr_due[0] == cyc) we = 1;
          void'(wr_due.pop_front());
        end
        if (rd_start >= 0) begin
          if (cyc == rd_start + WC + 3) begin
            re = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
            rd_start = -1;
          end
        end else if (bus.R_NEXT && m_occ > 0) begin
          rd_start = cyc;
        end
        if (we && !re) begin
          if (m_occ == DEPTH) m_ovr = 1;
          else m_occ++;
        end else if (re && !we) begin
          m_occ--;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    int  ph;
    bit  busy_e;
    forever begin
      @(negedge clk);
      #1;
      if (cyc >= 1) begin
        busy_e = (rd_start >= 0);
        ph     = cyc - rd_start;
        chk("busy", bus.R_BUSY, busy_e);
        chk("enable", bus.R_ENABLE, busy_e && ph <= WC + 1);
        chk("data_valid", bus.R_DATA_VALID, busy_e && ph == WC + 1);
        chk("address", bus.R_ADDRESS_OUT, m_ptr % HALF);
        chk("chip", bus.R_CHIP_SELECT, m_ptr / HALF);
        chk("occupancy", bus.OCCUPANCY, m_occ);
        chk("empty", bus.EMPTY, m_occ == 0);
        chk("full", bus.FULL, m_occ == DEPTH);
        chk("overrun", bus.OVERRUN, m_ovr);
        if (!bus.R_BUSY && bus.R_NEXT && !bus.EMPTY) last_idle = cyc;
        if (bus.R_DATA_VALID) begin
          rd_log.push_back({bus.R_CHIP_SELECT, bus.R_ADDRESS_OUT});
          lat_log.push_back(cyc - last_idle);
        end
      end
    end
  end

  task automatic wr_pulse(int hi, int lo);
    @(negedge clk);
    bus.W_NEXT = 1'b1;
    wr_due.push_back(cyc + 3);
    repeat (hi) @(negedge clk);
    bus.W_NEXT = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_model_start(string name);
    int n = 0;
    while (rd_start < 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rd_start < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int  r;
    bit  saw_busy;
    bit  writer_done;
    int  n;
    bus.W_NEXT = 1'b0;
    bus.R_NEXT = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", bus.R_BUSY, 0);
    chk("rst_enable", bus.R_ENABLE, 0);
    chk("rst_valid", bus.R_DATA_VALID, 0);
    chk("rst_addr", bus.R_ADDRESS_OUT, 0);
    chk("rst_chip", bus.R_CHIP_SELECT, 0);
    chk("rst_occ", bus.OCCUPANCY, 0);
    chk("rst_empty", bus.EMPTY, 1);
    chk("rst_full", bus.FULL, 0);
    chk("rst_overrun", bus.OVERRUN, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three writes; EMPTY falls on the third edge after the first rise.
    @(negedge clk);
    bus.W_NEXT = 1'b1;
    wr_due.push_back(cyc + 3);
    r = cyc;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (cyc == r + 2) chk("empty_before_evt", bus.EMPTY, 1);
      if (cyc == r + 3) chk("empty_after_evt", bus.EMPTY, 0);
    end
    bus.W_NEXT = 1'b0;
    repeat (4) @(negedge clk);
    wr_pulse(4, 4);
    wr_pulse(4, 4);
    rd_log.delete();
    lat_log.delete();
    bus.R_NEXT = 1'b1;
    repeat (3 * (WC + 4) + 6) @(negedge clk);
    bus.R_NEXT = 1'b0;
    chk("three_reads_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("read0_ptr", rd_log[0], 5'h00);
      chk("read1_ptr", rd_log[1], 5'h01);
      chk("read2_ptr", rd_log[2], 5'h02);
      for (int i = 0; i < 3; i++) chk("read_latency", lat_log[i], 4);
    end
    chk("drained_empty", bus.EMPTY, 1);
    chk("drained_occ", bus.OCCUPANCY, 0);

    // Requests while empty are ignored.
    do_reset();
    saw_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.R_NEXT = 1'b1;
      @(negedge clk);
      bus.R_NEXT = 1'b0;
      if (bus.R_BUSY || bus.R_ENABLE) saw_busy = 1;
    end
    repeat (3) @(negedge clk);
    chk("empty_req_busy", saw_busy, 0);
    chk("empty_req_addr", bus.R_ADDRESS_OUT, 0);

    // Wrap across the chip boundary.
    do_reset();
    repeat (HALF + 1) wr_pulse(2, 2);
    repeat (4) @(negedge clk);
    rd_log.delete();
    lat_log.delete();
    bus.R_NEXT = 1'b1;
    n = 0;
    while (rd_log.size() < HALF + 1 && n < (HALF + 1) * (WC + 4) + 20) begin
      @(negedge clk);
      n++;
    end
    bus.R_NEXT = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrap_count", rd_log.size(), HALF + 1);
    if (rd_log.size() == HALF + 1) begin
      chk("wrap_last_chip0", rd_log[HALF - 1], 5'h0F);
      chk("wrap_first_chip1", rd_log[HALF], 5'h10);
    end
    chk("wrap_empty", bus.EMPTY, 1);

    // Fill to full, then one write more.
    do_reset();
    repeat (DEPTH) wr_pulse(2, 2);
    repeat (4) @(negedge clk);
    chk("full_flag", bus.FULL, 1);
    chk("full_occ", bus.OCCUPANCY, 32);
    chk("full_no_overrun", bus.OVERRUN, 0);
    wr_pulse(2, 2);
    repeat (4) @(negedge clk);
    chk("overrun_set", bus.OVERRUN, 1);
    chk("overrun_occ", bus.OCCUPANCY, 32);

    // Full again, with a write landing on the ADVANCE cycle.
    do_reset();
    repeat (DEPTH) wr_pulse(2, 2);
    repeat (4) @(negedge clk);
    bus.R_NEXT = 1'b1;
    @(negedge clk);
    wait_model_start("coincide_start");
    bus.R_NEXT = 1'b0;
    n = 0;
    while (rd_start >= 0 && cyc < rd_start + WC && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.W_NEXT = 1'b1;
    wr_due.push_back(cyc + 3);
    repeat (3) @(negedge clk);
    bus.W_NEXT = 1'b0;
    repeat (6) @(negedge clk);
    chk("coincide_overrun", bus.OVERRUN, 0);
    chk("coincide_occ", bus.OCCUPANCY, 32);
    chk("coincide_full", bus.FULL, 1);

    // Reset during WAIT aborts the read.
    do_reset();
    repeat (2) wr_pulse(2, 2);
    repeat (4) @(negedge clk);
    bus.R_NEXT = 1'b1;
    @(negedge clk);
    wait_model_start("abort_start");
    bus.R_NEXT = 1'b0;
    @(negedge clk);
    chk("abort_in_wait_enable", bus.R_ENABLE, 1);
    rd_log.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.R_BUSY, 0);
    chk("abort_enable", bus.R_ENABLE, 0);
    chk("abort_addr", bus.R_ADDRESS_OUT, 0);
    chk("abort_occ", bus.OCCUPANCY, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_valid", rd_log.size(), 0);

    // Randomised concurrent writes and requests.
    do_reset();
    writer_done = 0;
    fork
      begin
        repeat (40) wr_pulse($urandom_range(2, 5), $urandom_range(2, 6));
        writer_done = 1;
      end
      begin
        while (!writer_done) begin
          @(negedge clk);
          bus.R_NEXT = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.R_NEXT = 1'b1;
    repeat (DEPTH * (WC + 4) + 10) @(negedge clk);
    bus.R_NEXT = 1'b0;
    repeat (4) @(negedge clk);
    chk("random_drained", bus.EMPTY, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
